// File: rtl/rotate_sequencer.sv
// rotate_sequencer: drives the 2-bit select of the 3-position word rotator.
// A prescaler sets the automatic step rate in RUN. Push inputs go through
// synchronizers and edge detectors that toggle RUN/PAUSE and single-step in PAUSE.
// The select walks 0,1,2 forward or backward and never shows the value 3.

// One push-input lane: a 2-flop synchronizer, an edge flop, and a registered
// rising-edge pulse. The pulse is registered once more so it lines up with
// the select/state update three edges after the input is first sampled.
module rotate_sequencer_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic [2:0] pipe;
    logic       pls_q;

    // synchronizer chain plus edge-history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[1:0], din};
    end

    // one-cycle pulse on a synchronized 0->1 transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pls_q <= 1'b0;
        else     pls_q <= pipe[1] & ~pipe[2];
    end

    assign pulse = pls_q;
endmodule

module rotate_sequencer #(
    parameter int TICKS = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       go,
    input  logic       step,
    input  logic       dir,
    output logic [1:0] sel,
    output logic       tick,
    output logic       running
);
    localparam int NUM_LANES = 2;
    localparam int CW        = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [NUM_LANES-1:0]   raw, pls;
    logic                   go_p, step_p;
    logic [1:0]             dir_pipe;
    logic                   dir_s;
    logic [CW-1:0]          cnt;
    logic                   wrap, adv;
    logic [1:0]             sel_nxt;

    // lane 0 = go, lane 1 = step
    assign raw    = {step, go};
    assign go_p   = pls[0];
    assign step_p = pls[1];

    rotate_sequencer_edge u_edge [NUM_LANES-1:0] (
        .clk   (CLOCK_50),
        .rst   (reset),
        .din   (raw),
        .pulse (pls)
    );

    // dir only needs a level; it is consulted at the next advance
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) dir_pipe <= '0;
        else       dir_pipe <= {dir_pipe[0], dir};
    end
    assign dir_s = dir_pipe[1];

    // state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= PAUSE;
        else       state <= state_nxt;
    end

    // next state: each go pulse toggles between RUN and PAUSE
    always_comb begin
        state_nxt = state;
        case (state)
            PAUSE:   if (go_p) state_nxt = RUN;
            RUN:     if (go_p) state_nxt = PAUSE;
            default: state_nxt = PAUSE;
        endcase
    end

    // outputs of the FSM: run flag and the advance strobe
    always_comb begin
        running = (state == RUN);
        wrap    = running && (cnt == LAST);
        // go takes priority over a step that lands in the same cycle
        adv     = wrap || (!running && step_p && !go_p);
    end

    // prescaler: cleared on RUN entry, free-running in RUN, ignored in PAUSE
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                      cnt <= '0;
        else if (state == PAUSE && go_p) cnt <= '0;
        else if (state == RUN)          cnt <= wrap ? '0 : cnt + CW'(1);
    end

    // modulo-3 successor/predecessor, wrapping directly so 3 never appears
    always_comb begin
        sel_nxt = sel;
        if (!dir_s) sel_nxt = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        else        sel_nxt = (sel == 2'd0) ? 2'd2 : sel - 2'd1;
    end

    // select register: only moves on an advance
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)    sel <= 2'd0;
        else if (adv) sel <= sel_nxt;
    end

    // tick marks the first cycle the new select is visible
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) tick <= 1'b0;
        else       tick <= adv;
    end
endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer with TICKS = 4. Each expected advance
// (select value and the cycle its tick should appear) is queued when the
// stimulus is applied and checked when the DUT raises tick.
module tb_rotate_sequencer;
    logic       CLOCK_50 = 1'b0;
    logic       reset, go, step, dir;
    logic [1:0] sel;
    logic       tick, running;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int c0;

    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    rotate_sequencer #(.TICKS(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .go       (go),
        .step     (step),
        .dir      (dir),
        .sel      (sel),
        .tick     (tick),
        .running  (running)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic push(input logic [1:0] s, input int c);
        exp_t e;
        e.sel = s;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // advance to the next falling edge and service the scoreboard
    task automatic cycle1();
        exp_t e;
        @(negedge CLOCK_50);
        if (tick === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_tick_at_cycle", cyc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("tick_sel", sel, e.sel);
                chk("tick_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            chk("missed_tick_cycle", cyc, e.cyc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle1();
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; step = 1'b0; dir = 1'b0;
        run(3);
        chk("reset_sel", sel, 0);
        chk("reset_tick", tick, 0);
        chk("reset_running", running, 0);
        reset = 1'b0;
        run(2);

        // run forward: entry 4 edges after drive, ticks every 4 after that
        c0 = cyc;
        go = 1'b1;
        push(2'd1, c0 + 8);  push(2'd2, c0 + 12); push(2'd0, c0 + 16);
        push(2'd1, c0 + 20); push(2'd2, c0 + 24);
        run(2); go = 1'b0;
        run(1); chk("fwd_running_before", running, 0);
        run(1); chk("fwd_running_after", running, 1);
        run(20);
        chk("fwd_sb_drained", sb.size(), 0);

        // asynchronous reset mid-RUN with sel = 2
        #1 reset = 1'b1;
        #1;
        chk("async_rst_sel", sel, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_tick", tick, 0);
        run(2);
        reset = 1'b0;
        run(12);
        chk("post_rst_sel", sel, 0);
        chk("post_rst_running", running, 0);

        // backward run, then switch dir mid-interval
        c0 = cyc;
        dir = 1'b1; go = 1'b1;
        push(2'd2, c0 + 8); push(2'd1, c0 + 12);
        run(2); go = 1'b0;
        run(10);
        dir = 1'b0;
        push(2'd2, c0 + 16);
        run(4);
        // stop on the boundary: go pulse lands on prescaler = TICKS-1
        go = 1'b1;
        push(2'd0, c0 + 20);
        run(2); go = 1'b0;
        run(2);
        chk("stop_boundary_running", running, 0);
        run(20);
        chk("stop_stable_sel", sel, 0);
        chk("stop_stable_running", running, 0);
        chk("bwd_sb_drained", sb.size(), 0);

        // single step in PAUSE with step held high for 10 cycles
        c0 = cyc;
        step = 1'b1;
        push(2'd1, c0 + 4);
        run(10); step = 1'b0;
        run(4);
        chk("step_running", running, 0);

        // step pulse in RUN must not disturb the cadence
        c0 = cyc;
        go = 1'b1;
        push(2'd2, c0 + 8); push(2'd0, c0 + 12); push(2'd1, c0 + 16);
        run(2); go = 1'b0;
        run(7);
        step = 1'b1;
        run(2); step = 1'b0;
        run(5);
        go = 1'b1;
        push(2'd2, c0 + 20);
        run(2); go = 1'b0;
        run(2);
        chk("run_step_stop_running", running, 0);
        run(4);

        // collision: go and step together in PAUSE
        c0 = cyc;
        go = 1'b1; step = 1'b1;
        push(2'd0, c0 + 8);
        run(2); go = 1'b0; step = 1'b0;
        run(2);
        chk("collide_running", running, 1);
        chk("collide_no_extra_adv", sel, 2);
        run(4);
        reset = 1'b1;
        run(2);
        chk("final_running", running, 0);
        reset = 1'b0;
        run(2);
        chk("final_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Generates the 2-bit rotation select consumed by the 3-position "dE1" word-rotator/decoder stage, replacing the manual switch pair with automatic or single-stepped rotation. A prescaler turns the board clock into a step rate. A two-state run/pause FSM, driven by debounced-edge push inputs, advances a modulo-3 select counter forward or backward. Output `sel` connects directly to the rotator's 2-bit select input.

## Interface
- `TICKS`, 50_000_000, clock cycles per rotation step in RUN; legal range ≥ 2.
- `CLOCK_50`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `go`  in  1  asynchronous level input; each rising edge toggles between RUN and PAUSE.
- `step`  in  1  asynchronous level input; each rising edge advances `sel` one position, in PAUSE only.
- `dir`  in  1  asynchronous level input; 0 = forward (0→1→2→0), 1 = backward (0→2→1→0).
- `sel`  out  2  rotation select to the rotator; only values 0, 1, 2 are ever driven.
- `tick`  out  1  one-cycle pulse in the same cycle `sel` first shows a new value.
- `running`  out  1  1 in RUN, 0 in PAUSE.

## Operation
- **Input conditioning:** `go`, `step` and `dir` each pass through a 2-flop synchronizer. `go` and `step` then feed a rising-edge detector (third flop), producing one-cycle `go_p` and `step_p`.
- **FSM states:** PAUSE (reset state) and RUN.
  - PAUSE → RUN on `go_p`. The prescaler clears to 0 on this transition.
  - RUN → PAUSE on `go_p`. The prescaler holds its value but is ignored, because it clears again on the next RUN entry.
- **Prescaler:** width is clog2(TICKS). It increments every cycle in RUN. When count == TICKS−1 it wraps to 0 and asserts internal `adv`.
- **Step in PAUSE:** `step_p` asserts `adv`. `step_p` has no effect in RUN.
- **Simultaneous `go_p` and `step_p`:** `go_p` wins and `step_p` is dropped.
- **Advance:** on `adv`, `sel` moves to its next value using the synchronized `dir`.
  - Forward: 2 → 0.
  - Backward: 0 → 2.
  - No intermediate value 3 ever appears.
- **`dir` changes:** take effect at the next advance only. The prescaler phase is unaffected.
- **`tick`:** registered copy of `adv`, so it is high in the first cycle `sel` holds its new value.
- **`running`:** equals (state == RUN).

## Timing
- **Reset values** (asserted or released at any time, including mid-count):
  - `sel` = 0, `tick` = 0, `running` = 0.
  - State = PAUSE, prescaler = 0, synchronizer and edge flops = 0.
- **`go` latency:**
  - Input rise sampled at edge k gives `go_p` high during cycle k+2.
  - `running` changes at edge k+3.
- **`step` latency:** input rise sampled at edge k gives `sel` and `tick` updated at edge k+3.
- **RUN cadence:**
  - The first advance occurs TICKS cycles after the RUN-entry edge.
  - Subsequent advances come exactly every TICKS cycles.
  - `tick` stays high for exactly one cycle per advance.
- **Leaving RUN on the advance cycle:** if `go_p` coincides with prescaler == TICKS−1, the advance still happens on that edge and the state becomes PAUSE.
- **Held inputs:** a `go` or `step` held high produces exactly one pulse. Another pulse requires a low of at least one synchronized cycle.
- **`sel` stability:** `sel` is a registered output with no combinational path from any input.

## Test plan
All scenarios use `TICKS` = 4.
- **Reset:** pulse `reset` mid-RUN with `sel` = 2.
  - `sel` = 0, `running` = 0 and `tick` = 0 asynchronously.
  - After release, no advance occurs without `go`.
- **Run forward:** pulse `go` with `dir` = 0.
  - `running` rises 3 cycles later.
  - `sel` sequence 1, 2, 0, 1 at 4-cycle spacing, with one `tick` per change.
- **Run backward, direction change:** run with `dir` = 1, giving `sel` 0 → 2 → 1. Set `dir` = 0 mid-interval.
  - The next advance gives 2.
  - Spacing stays 4 cycles.
- **Single step in PAUSE:** hold `step` high for 10 cycles.
  - Exactly one advance, 0 → 1, with `tick` 3 cycles after the rise.
  - Pulsing `step` in RUN does not change cadence.
- **Collision:** `go` and `step` rise in the same cycle during PAUSE.
  - Enters RUN with no extra advance.
  - First advance comes 4 cycles after RUN entry.
- **Stop on boundary:** time `go` so `go_p` lands on prescaler = 3.
  - `sel` advances once, `running` = 0.
  - `sel` is then stable for 20 cycles.
